// File: rtl/char_renderer.sv
// char_renderer: 80x25 text-mode pixel pipeline with buffer/font lookup, inverse video and blinking cursor.
// Fixed 3-cycle latency from sync-generator position to pixel, syncs delayed to match.
module char_renderer #(
    parameter int COLS         = 80,
    parameter int ROWS         = 25,
    parameter int ADDR_WIDTH   = 11,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [9:0]            hpos,
    input  logic [9:0]            vpos,
    input  logic                  active_in,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    output logic [ADDR_WIDTH-1:0] buf_raddr,
    output logic                  buf_read_en,
    input  logic [7:0]            buf_dout,
    output logic [10:0]           font_addr,
    input  logic [7:0]            font_data,
    input  logic [6:0]            cursor_x,
    input  logic [4:0]            cursor_y,
    input  logic                  cursor_en,
    output logic                  pixel,
    output logic                  active,
    output logic                  hsync,
    output logic                  vsync
);

    logic [6:0]            col;
    logic [4:0]            row;
    logic [3:0]            scan;
    logic                  in_area;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] addr_hold;
    logic [10:0]           font_hold;
    logic                  load_d1;
    logic                  load_d2;
    logic [6:0]            col_d1;
    logic [4:0]            row_d1;
    logic [3:0]            scan_d1;
    logic                  inv;
    logic                  cur_hit;
    logic [7:0]            shreg;
    logic [2:0]            act_d;
    logic [2:0]            hs_d;
    logic [2:0]            vs_d;
    logic [2:0]            area_d;
    logic                  vs_prev;
    logic [7:0]            frame_cnt;
    logic                  blink_on;
    logic                  frame_wrap;

    assign col  = hpos[9:3];
    assign row  = vpos[8:4];
    assign scan = vpos[3:0];
    // vpos[9] catches scanlines 512+ whose low bits alias onto valid rows
    assign in_area = (32'(col) < COLS) && (32'(row) < ROWS) && !vpos[9];
    assign addr = ADDR_WIDTH'({row, 6'd0}) + ADDR_WIDTH'({row, 4'd0}) + ADDR_WIDTH'(col);

    assign buf_read_en = reset_n && active_in && in_area && (hpos[2:0] == 3'd0);
    assign buf_raddr   = buf_read_en ? addr : addr_hold;
    assign font_addr   = load_d1 ? {buf_dout[6:0], scan_d1} : font_hold;
    assign frame_wrap  = frame_cnt == 8'(BLINK_FRAMES - 1);

    assign pixel  = shreg[7] && act_d[2] && area_d[2];
    assign active = act_d[2];
    assign hsync  = hs_d[2];
    assign vsync  = vs_d[2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_hold <= '0;
            font_hold <= '0;
            load_d1   <= 1'b0;
            load_d2   <= 1'b0;
            col_d1    <= '0;
            row_d1    <= '0;
            scan_d1   <= '0;
            inv       <= 1'b0;
            cur_hit   <= 1'b0;
            shreg     <= '0;
            act_d     <= '0;
            hs_d      <= '0;
            vs_d      <= '0;
            area_d    <= '0;
        end else begin
            if (buf_read_en) addr_hold <= addr;
            if (load_d1) font_hold <= font_addr;
            load_d1 <= buf_read_en;
            load_d2 <= load_d1;
            col_d1  <= col;
            row_d1  <= row;
            scan_d1 <= scan;
            inv     <= buf_dout[7];
            cur_hit <= cursor_en && (col_d1 == cursor_x) && (row_d1 == cursor_y) && blink_on;
            // inverse and cursor cancel each other when both apply
            shreg   <= load_d2 ? font_data ^ {8{inv ^ cur_hit}} : {shreg[6:0], 1'b0};
            act_d   <= {act_d[1:0], active_in};
            hs_d    <= {hs_d[1:0], hsync_in};
            vs_d    <= {vs_d[1:0], vsync_in};
            area_d  <= {area_d[1:0], in_area};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_prev   <= 1'b0;
            frame_cnt <= '0;
            blink_on  <= 1'b1;
        end else begin
            vs_prev <= vsync_in;
            if (vsync_in && !vs_prev) begin
                frame_cnt <= frame_wrap ? 8'd0 : frame_cnt + 8'd1;
                if (frame_wrap) blink_on <= ~blink_on;
            end
        end
    end

endmodule

// File: tb/tb_char_renderer.sv
// tb_char_renderer: directed tables, hand sequences and random cells checked against a pixel-level model.
module tb_char_renderer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  hpos = '0;
    logic [9:0]  vpos = '0;
    logic        active_in = 1'b0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic [10:0] buf_raddr;
    logic        buf_read_en;
    logic [7:0]  buf_dout = '0;
    logic [10:0] font_addr;
    logic [7:0]  font_data = '0;
    logic [6:0]  cursor_x = '0;
    logic [4:0]  cursor_y = '0;
    logic        cursor_en = 1'b0;
    logic        pixel;
    logic        active;
    logic        hsync;
    logic        vsync;

    always #5 clk = ~clk;

    char_renderer dut (
        .clk(clk), .reset_n(reset_n), .hpos(hpos), .vpos(vpos),
        .active_in(active_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .buf_raddr(buf_raddr), .buf_read_en(buf_read_en), .buf_dout(buf_dout),
        .font_addr(font_addr), .font_data(font_data),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_en(cursor_en),
        .pixel(pixel), .active(active), .hsync(hsync), .vsync(vsync)
    );

    // character buffer RAM and font ROM, both 1-cycle synchronous reads
    logic [7:0] mem  [0:2047];
    logic [7:0] font [0:2047];
    always @(posedge clk) begin
        if (buf_read_en) buf_dout <= mem[buf_raddr];
        font_data <= font[font_addr];
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct { logic chk; logic pix; logic act; logic hs; logic vs; } exp_t;
    exp_t q[$];
    int   rises;
    logic vs_last;
    int   raddr_m;

    // pixel for a screen position straight from the display rules
    function automatic logic model_pix(input int h, input int v, input logic a);
        int col, row, scan;
        logic [7:0] ch, g;
        logic hit;
        if (!a || h >= 640 || v >= 400) return 1'b0;
        col  = h / 8;
        row  = v / 16;
        scan = v % 16;
        ch   = mem[row * 80 + col];
        g    = font[int'(ch[6:0]) * 16 + scan];
        hit  = cursor_en && (int'(cursor_x) == col) && (int'(cursor_y) == row) && ((rises / 32) % 2 == 0);
        return g[7 - h % 8] ^ ch[7] ^ hit;
    endfunction

    task automatic tick(input int h, input int v, input logic a, input logic hs, input logic vs, input logic chk);
        exp_t e;
        logic en_e;
        hpos = 10'(h);
        vpos = 10'(v);
        active_in = a;
        hsync_in = hs;
        vsync_in = vs;
        if (vs && !vs_last) rises++;
        vs_last = vs;
        en_e = a && h < 640 && v < 400 && (h % 8 == 0);
        if (en_e) raddr_m = (v / 16) * 80 + h / 8;
        #1;
        check("read_en", buf_read_en, en_e);
        check("raddr", buf_raddr, raddr_m);
        check("raddr_range", buf_raddr < 11'd2000, 1);
        e = '{chk, model_pix(h, v, a), a, hs, vs};
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 3) begin
            e = q.pop_front();
            check("active_dly", active, e.act);
            check("hsync_dly", hsync, e.hs);
            check("vsync_dly", vsync, e.vs);
            if (e.chk) check("pixel", pixel, e.pix);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        hpos = '0;
        vpos = '0;
        active_in = 1'b1;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pixel", pixel, 0);
        check("rst_active", active, 0);
        check("rst_hsync", hsync, 0);
        check("rst_vsync", vsync, 0);
        check("rst_read_en", buf_read_en, 0);
        check("rst_raddr", buf_raddr, 0);
        check("rst_font_addr", font_addr, 0);
        reset_n = 1'b1;
        active_in = 1'b0;
        q.delete();
        rises = 0;
        vs_last = 1'b0;
        raddr_m = 0;
    endtask

    // one full cell plus two idle cycles; returns its 8 pixels (bit 7 first) and font address
    task automatic cell_pixels(input int col, input int row, input int scan, output logic [7:0] pix, output logic [10:0] fa);
        pix = '0;
        fa = '0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) tick(col * 8 + i, row * 16 + scan, 1'b1, 1'b0, 1'b0, 1'b1);
            else tick(700, 450, 1'b0, 1'b0, 1'b0, 1'b1);
            if (i == 0) fa = font_addr;
            if (i >= 2) pix[9 - i] = pixel;
        end
    endtask

    task automatic vsync_pulses(input int n);
        repeat (n) begin
            tick(700, 450, 1'b0, 1'b0, 1'b1, 1'b0);
            tick(700, 450, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    typedef struct { int h; int v; logic a; logic en; int addr; } avec_t;
    avec_t tbl [10];

    initial begin
        logic [7:0] pix;
        logic [10:0] fa;
        int col, row, scan, v;
        logic a;

        foreach (mem[i]) mem[i] = 8'($urandom);
        foreach (font[i]) font[i] = 8'($urandom);
        for (int s = 0; s < 16; s++) font[s] = 8'h00;
        font[11'h415] = 8'hA5;
        font[11'h7F0] = 8'hFF;
        mem[410] = 8'h41;
        mem[163] = 8'h00;
        mem[239] = 8'h00;
        mem[1923] = 8'h00;
        mem[0] = 8'h7F;
        mem[1] = 8'h7F;

        tbl = '{
            '{0,    0,   1'b1, 1'b1, 0},
            '{632,  399, 1'b1, 1'b1, 1999},
            '{640,  399, 1'b1, 1'b0, 1999},
            '{8,    16,  1'b1, 1'b1, 81},
            '{0,    400, 1'b1, 1'b0, 81},
            '{0,    600, 1'b1, 1'b0, 81},
            '{3,    0,   1'b1, 1'b0, 81},
            '{0,    0,   1'b0, 1'b0, 81},
            '{624,  200, 1'b1, 1'b1, 1038},
            '{1016, 0,   1'b1, 1'b0, 1038}
        };

        do_reset();
        foreach (tbl[i]) begin
            hpos = 10'(tbl[i].h);
            vpos = 10'(tbl[i].v);
            active_in = tbl[i].a;
            #1;
            check($sformatf("tbl%0d_read_en", i), buf_read_en, tbl[i].en);
            check($sformatf("tbl%0d_raddr", i), buf_raddr, tbl[i].addr);
            @(posedge clk);
            #1;
        end

        do_reset();
        cell_pixels(10, 5, 5, pix, fa);
        check("glyph_font_addr", fa, 11'h415);
        check("glyph_pixels", pix, 8'hA5);
        mem[410] = 8'hC1;
        cell_pixels(10, 5, 5, pix, fa);
        check("inverse_pixels", pix, 8'h5A);
        cursor_x = 7'd10;
        cursor_y = 5'd5;
        cursor_en = 1'b1;
        cell_pixels(10, 5, 5, pix, fa);
        check("inverse_cursor_cancel", pix, 8'hA5);
        mem[410] = 8'h41;
        cell_pixels(10, 5, 5, pix, fa);
        check("cursor_normal", pix, 8'h5A);
        cursor_x = 7'd80;
        cursor_y = 5'd2;
        cell_pixels(79, 2, 0, pix, fa);
        check("cursor_x_oob", pix, 8'h00);
        cursor_x = 7'd3;
        cursor_y = 5'd25;
        cell_pixels(3, 24, 0, pix, fa);
        check("cursor_y_oob", pix, 8'h00);

        do_reset();
        cursor_x = 7'd3;
        cursor_y = 5'd2;
        cursor_en = 1'b1;
        for (int s = 0; s < 16; s++) begin
            cell_pixels(3, 2, s, pix, fa);
            check("blink_on", pix, 8'hFF);
        end
        vsync_pulses(32);
        for (int s = 0; s < 16; s++) begin
            cell_pixels(3, 2, s, pix, fa);
            check("blink_off", pix, 8'h00);
        end
        vsync_pulses(32);
        for (int s = 0; s < 16; s++) begin
            cell_pixels(3, 2, s, pix, fa);
            check("blink_on_again", pix, 8'hFF);
        end
        cursor_en = 1'b0;

        tick(700, 450, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(700, 450, 1'b0, 1'b1, 1'b0, 1'b0);
        check("hsync_t1", hsync, 0);
        tick(700, 450, 1'b0, 1'b0, 1'b0, 1'b0);
        check("hsync_t2", hsync, 0);
        tick(700, 450, 1'b0, 1'b0, 1'b0, 1'b0);
        check("hsync_t3", hsync, 1);
        tick(700, 450, 1'b0, 1'b0, 1'b0, 1'b0);
        check("hsync_t4", hsync, 0);

        // reset lands while a lit glyph is shifting out
        do_reset();
        for (int h = 0; h < 5; h++) tick(h, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        check("pre_reset_pixel", pixel, 1);
        hpos = 10'd5;
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_pixel", pixel, 0);
        check("midrst_active", active, 0);
        check("midrst_hsync", hsync, 0);
        check("midrst_vsync", vsync, 0);
        check("midrst_read_en", buf_read_en, 0);
        check("midrst_raddr", buf_raddr, 0);
        check("midrst_font_addr", font_addr, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        q.delete();
        rises = 0;
        vs_last = 1'b0;
        raddr_m = 0;
        for (int h = 5; h < 8; h++) begin
            tick(h, 0, 1'b1, 1'b0, 1'b0, 1'b0);
            check("post_rst_pixel", pixel, 0);
        end
        cell_pixels(1, 0, 0, pix, fa);
        check("post_rst_cell", pix, 8'hFF);

        repeat (250) begin
            if ($urandom_range(0, 7) == 0) vsync_pulses(1 + int'($urandom_range(0, 3)));
            col  = int'($urandom_range(0, 84));
            row  = int'($urandom_range(0, 26));
            scan = int'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) col = int'($urandom_range(80, 127));
            v = row * 16 + scan;
            if ($urandom_range(0, 9) == 0) v = int'($urandom_range(400, 1023));
            a = $urandom_range(0, 9) != 0;
            if ((v / 16) * 80 + col < 2048) mem[(v / 16) * 80 + col] = 8'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                cursor_x = 7'(col);
                cursor_y = 5'(v / 16);
            end else begin
                cursor_x = 7'($urandom);
                cursor_y = 5'($urandom);
            end
            cursor_en = $urandom_range(0, 3) != 0;
            for (int i = 0; i < 8; i++) tick(col * 8 + i, v, a, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        end
        tick(700, 450, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(700, 450, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/char_renderer.md
Name: char_renderer

Overview:
- Text-mode video stage directly downstream of the 80x25 character buffer RAM.
- Each cycle it takes the pixel position from the VGA sync generator and drives the buffer read port (synchronous, 1-cycle read latency).
- It looks up glyph rows in the synchronous font ROM (1-cycle latency) and serialises them into a 1-bit pixel stream.
- Before output it applies inverse video and a blinking block cursor, and delays the sync signals to stay aligned with the pixels.

Parameters:
- COLS, 80, characters per row.
- ROWS, 25, character rows.
- ADDR_WIDTH, 11, character buffer address width. Covers addresses 0..1999.
- BLINK_FRAMES, 32, frames per cursor blink half-period.

Ports:
- clk  input  1  pixel clock. Sole clock.
- reset_n  input  1  asynchronous, active-low reset.
- hpos  input  10  current pixel column from the sync generator.
- vpos  input  10  current scanline from the sync generator.
- active_in  input  1  sync generator display-enable.
- hsync_in  input  1  horizontal sync from the sync generator.
- vsync_in  input  1  vertical sync from the sync generator.
- buf_raddr  output  ADDR_WIDTH  character buffer read address.
- buf_read_en  output  1  character buffer read enable.
- buf_dout  input  8  character buffer read data. Valid 1 cycle after buf_read_en.
- font_addr  output  11  font ROM address {char[6:0], scanline[3:0]}.
- font_data  input  8  font ROM row. Bit 7 is the leftmost pixel. Valid 1 cycle after font_addr.
- cursor_x  input  7  cursor column.
- cursor_y  input  5  cursor row.
- cursor_en  input  1  cursor visible enable.
- pixel  output  1  video out. 1 = lit.
- active  output  1  active_in delayed 3 cycles.
- hsync  output  1  hsync_in delayed 3 cycles.
- vsync  output  1  vsync_in delayed 3 cycles.

Behaviour:
- Cell geometry:
  - 8x16 pixels per cell; 640x400 active area.
  - col = hpos[9:3]; row = vpos[8:4]; scan = vpos[3:0].
- Stage 0 (cycle T):
  - buf_read_en = active_in & hpos[2:0]==0 & col<COLS & row<ROWS.
  - buf_raddr = row*80 + col, computed as (row<<6)+(row<<4)+col, with no multiplier.
  - When buf_read_en is low, buf_raddr holds its previous value.
- Stage 1 (T+1):
  - font_addr = {buf_dout[6:0], scan_d1}.
  - Register inv = buf_dout[7].
  - Register cur_hit = cursor_en & col_d1==cursor_x & row_d1==cursor_y & blink_on.
- Stage 2 (T+2):
  - On load_d2, the 8-bit shift register loads font_data ^ {8{inv ^ cur_hit}}.
  - Otherwise it shifts left, filling with 0.
- Output (T+3):
  - pixel = shreg[7] & active.
  - Fixed latency: the pixel for the position presented at T appears at T+3.
- Alignment:
  - hsync, vsync and active are 3-stage shift delays of their inputs.
  - Column, row, scan and load flags travel alongside in matching pipeline registers.
- Blink:
  - An 8-bit frame counter increments on each rising edge of vsync_in.
  - When it reaches BLINK_FRAMES-1 it wraps to 0 and toggles blink_on.
- Reset values:
  - pixel, active, hsync, vsync, buf_read_en = 0.
  - buf_raddr = 0; font_addr = 0; shreg = 0.
  - Frame counter = 0; blink_on = 1.
  - All pipeline registers = 0.
- Boundaries:
  - hpos>=640 or vpos>=400: no read is issued and pixel = 0, even if active_in is erroneously high.
  - Cursor with cursor_x>=80 or cursor_y>=25 is never displayed.
  - Address 1999 (row 24, col 79) is the maximum. No address >=2000 is ever driven.
  - Glyph scan wraps each 16 lines via vpos[3:0].
  - Inverse video and cursor both active on the same cell: they cancel, giving the normal glyph.
  - Reset asserted mid-line: the pipeline clears immediately. After release, outputs stay 0 until fresh inputs propagate (3 cycles).
  - cursor_* changing mid-cell: sampled once per cell at stage 1.

Test Plan:
- Address: hpos=0, vpos=0, active_in=1 -> buf_read_en=1, buf_raddr=0. hpos=632, vpos=399 -> buf_raddr=1999.
- Glyph: buf_dout=0x41, scan=5, font_data=0xA5 -> font_addr=0x415. pixel sequence from T+3 is 1,0,1,0,0,1,0,1.
- Inverse: buf_dout=0xC1, font_data=0xA5 -> pixels 0,1,0,1,1,0,1,0. With the cursor also on this cell -> 1,0,1,0,0,1,0,1.
- Cursor blink: cursor_en=1 at (3,2), blank char (font_data=0x00) -> all 128 pixels of the cell are 1. After 32 vsync rising edges the cell is 0; after 64 it is 1 again.
- Sync alignment: hsync_in pulse at cycle 100 -> hsync pulse at cycle 103. active_in low -> pixel=0 and buf_read_en=0.
- Reset: assert reset_n=0 mid-cell while pixels are shifting -> all outputs 0 the same cycle. Release -> first valid pixel 3 cycles after the next cell start.
